// File: rtl/uart_rx_cmd_if.sv
// Keystroke link between the UART receiver and the snake game logic.
// slave = receiver side (samples rx, drives the byte strobe), master = line/consumer side.
interface uart_rx_cmd_if;
  logic       rx;
  logic [7:0] dataRX;
  logic       WR_RX;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  rx,
    output dataRX,
    output WR_RX,
    output frame_err,
    output busy
  );

  modport master (
    output rx,
    input  dataRX,
    input  WR_RX,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 8N1 UART receiver delivering host keystroke bytes as dataRX/WR_RX in px_clk.
// Define UART_RX_PARITY_EN for 8E1 framing; a parity mismatch is reported as frame_err.
module uart_rx_cmd #(
  parameter int CLK_HZ = 31_500_000,
  parameter int BAUD   = 115_200
) (
  input  logic          px_clk,
  input  logic          rst,
  uart_rx_cmd_if.slave  bus
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, ERR} state_t;
`endif

  state_t          state_reg, state_next;
  logic [1:0]      sync_reg;
  logic            rxs;
  logic [CW-1:0]   clk_cnt_reg, clk_cnt_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]      shreg_reg, shreg_next;
  logic [7:0]      data_reg, data_next;
  logic            wr_reg, wr_next;
  logic            ferr_reg, ferr_next;
  logic            par_ok;

  // Two-flop synchronizer; both stages come out of reset as an idle (high) line.
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) sync_reg <= 2'b11;
    else     sync_reg <= {sync_reg[0], bus.rx};
  end
  assign rxs = sync_reg[1];

`ifdef UART_RX_PARITY_EN
  logic par_bad_reg, par_bad_next;
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) par_bad_reg <= 1'b0;
    else     par_bad_reg <= par_bad_next;
  end
  assign par_ok = ~par_bad_reg;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
      data_reg    <= '0;
      wr_reg      <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      data_reg    <= data_next;
      wr_reg      <= wr_next;
      ferr_reg    <= ferr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    data_next    = data_reg;
    wr_next      = 1'b0;
    ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!rxs) begin
          state_next   = START;
          clk_cnt_next = '0;
        end
      end
      // Half a bit in, the start bit must still be low or it was a glitch.
      START: begin
        if (clk_cnt_reg == HALF_CNT) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = rxs ? IDLE : DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + ONE_CNT;
        end
      end
      DATA: begin
        if (clk_cnt_reg == FULL_CNT) begin
          clk_cnt_next = '0;
          shreg_next   = {rxs, shreg_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + ONE_CNT;
        end
      end
`ifdef UART_RX_PARITY_EN
      // Even parity: data plus parity bit must hold an even number of ones.
      PARITY: begin
        if (clk_cnt_reg == FULL_CNT) begin
          clk_cnt_next = '0;
          par_bad_next = ^{rxs, shreg_reg};
          state_next   = STOP;
        end else begin
          clk_cnt_next = clk_cnt_reg + ONE_CNT;
        end
      end
`endif
      // Leaving at stop-bit middle lets a start bit follow a single stop bit directly.
      STOP: begin
        if (clk_cnt_reg == FULL_CNT) begin
          clk_cnt_next = '0;
          if (rxs && par_ok) begin
            wr_next    = 1'b1;
            data_next  = shreg_reg;
            state_next = IDLE;
          end else if (rxs) begin
            ferr_next  = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = ERR;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + ONE_CNT;
        end
      end
      ERR: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.dataRX    = data_reg;
  assign bus.WR_RX     = wr_reg;
  assign bus.frame_err = ferr_reg;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx_cmd.sv
// Randomized bench for uart_rx_cmd: frames are scored against outcome/latency rules
// derived from the frame contents (8N1, or 8E1 when UART_RX_PARITY_EN is defined).
module tb_uart_rx_cmd;
  localparam int N   = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB  = 11;
  localparam int LAT = 2 + 9*N + N/2 + 1 + N;
`else
  localparam int NB  = 10;
  localparam int LAT = 2 + 9*N + N/2 + 1;
`endif

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         start;
  } exp_t;

  logic px_clk = 1'b0;
  logic rst    = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last_good = 8'h00;
  exp_t exp_q[$];
  exp_t mon_e;

  uart_rx_cmd_if bus();

  uart_rx_cmd #(.CLK_HZ(1_000_000), .BAUD(62_500)) dut (
    .px_clk (px_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 px_clk = ~px_clk;
  always @(posedge px_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding frame's predicted outcome.
  always @(negedge px_clk) begin
    if (rst) begin
      last_good = 8'h00;
    end else begin
      if (bus.WR_RX || bus.frame_err) begin
        check_eq("pulse_exclusive", {31'b0, bus.WR_RX & bus.frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("spurious_pulse", {30'b0, bus.WR_RX, bus.frame_err}, 32'd0);
        end else begin
          int d;
          mon_e = exp_q.pop_front();
          d = cyc - mon_e.start;
          check_eq("pulse_kind", {31'b0, bus.frame_err}, {31'b0, mon_e.is_err});
          check_eq("latency", (d >= LAT-1 && d <= LAT+1) ? LAT : d, LAT);
          if (mon_e.is_err) begin
            check_eq("data_hold", {24'b0, bus.dataRX}, {24'b0, last_good});
          end else begin
            check_eq("data_rx", {24'b0, bus.dataRX}, {24'b0, mon_e.data});
            last_good = mon_e.data;
          end
          $display("frame d=%02h err=%0d wr=%0d ferr=%0d dataRX=%02h lat=%0d",
                   mon_e.data, mon_e.is_err, bus.WR_RX, bus.frame_err, bus.dataRX, d);
        end
      end else if (exp_q.size() != 0 && (cyc - exp_q[0].start) > LAT + 1) begin
        mon_e = exp_q.pop_front();
        check_eq("missing_pulse", 32'd0, 32'd1);
      end
    end
  end

  task automatic tx_bits(input logic [10:0] fr, input int nb);
    for (int i = 0; i < nb; i++) begin
      bus.rx = fr[i];
      repeat (N) @(negedge px_clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    logic [10:0] fr;
    exp_t e;
`ifdef UART_RX_PARITY_EN
    fr = {stop, (^d) ^ par_flip, d, 1'b0};
`else
    fr = {1'b0, stop, d, 1'b0};
`endif
    e.is_err = !stop || par_flip;
    e.data   = d;
    e.start  = cyc;
    exp_q.push_back(e);
    tx_bits(fr, NB);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge px_clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4*LAT) begin
      @(negedge px_clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] fr;
    int cnt;
    bus.rx = 1'b1;
    repeat (3) @(negedge px_clk);
    check_eq("rst_data",  {24'b0, bus.dataRX}, 32'd0);
    check_eq("rst_wr",    {31'b0, bus.WR_RX}, 32'd0);
    check_eq("rst_ferr",  {31'b0, bus.frame_err}, 32'd0);
    check_eq("rst_busy",  {31'b0, bus.busy}, 32'd0);
    rst = 1'b0;
    idle(5);

    // Start-bit glitch: short busy, no pulses, data untouched.
    bus.rx = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge px_clk);
      if (i == 4) bus.rx = 1'b1;
      if (bus.busy) cnt++;
    end
    check_eq("glitch_busy_len", {31'b0, (cnt > 0 && cnt <= 10)}, 32'd1);
    check_eq("glitch_busy_end", {31'b0, bus.busy}, 32'd0);
    check_eq("glitch_data", {24'b0, bus.dataRX}, 32'd0);

    send_frame(8'h41, 1'b1, 1'b0);
    check_eq("busy_after_frame", {31'b0, bus.busy}, 32'd0);
    idle(10);
    drain();

    // Bad stop bit then a held-low line: one frame_err, stays out of IDLE until rx rises.
    send_frame(8'h43, 1'b0, 1'b0);
    repeat (40) @(negedge px_clk);
    check_eq("break_busy", {31'b0, bus.busy}, 32'd1);
    idle(4);
    check_eq("break_release", {31'b0, bus.busy}, 32'd0);
    check_eq("break_data", {24'b0, bus.dataRX}, 32'h41);
    drain();

    send_frame(8'h44, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0);
    idle(10);
    drain();
    check_eq("b2b_data", {24'b0, bus.dataRX}, 32'h42);

    // Reset during data bit 3 aborts the byte; the next frame decodes.
    fr = {2'b01, 8'h41, 1'b0};
    tx_bits(fr, 4);
    bus.rx = fr[4];
    repeat (5) @(negedge px_clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_data", {24'b0, bus.dataRX}, 32'd0);
    check_eq("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check_eq("midrst_wr",   {31'b0, bus.WR_RX}, 32'd0);
    repeat (3) @(negedge px_clk);
    bus.rx = 1'b1;
    rst = 1'b0;
    idle(4);
    send_frame(8'h44, 1'b1, 1'b0);
    idle(10);
    drain();
    check_eq("postrst_data", {24'b0, bus.dataRX}, 32'h44);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h41, 1'b1, 1'b0);
    idle(5);
    send_frame(8'h41, 1'b1, 1'b1);
    idle(10);
    drain();
    check_eq("parity_data", {24'b0, bus.dataRX}, 32'h41);
`endif

    for (int k = 0; k < 16; k++) begin
      logic [7:0] d;
      logic bad, pf;
      int gap;
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
`ifdef UART_RX_PARITY_EN
      pf  = ($urandom_range(0, 5) == 0);
`else
      pf  = 1'b0;
`endif
      send_frame(d, !bad, pf);
      gap = bad ? $urandom_range(2, 20) :
            (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20));
      idle(gap);
    end
    idle(10);
    drain();
    check_eq("final_data", {24'b0, bus.dataRX}, {24'b0, last_good});
    check_eq("final_busy", {31'b0, bus.busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
